irrigation_actuator_sequencer: RTL and testbench

//  Downstream stage of the combinational irrigation controller. Consumes its gotejamento/aspersao/valvulaEntrada/alarme

---
 rtl/rega_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/irrigation_actuator_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_irrigation_actuator_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// rtl/rega_pkg.sv - shared state encoding and default timing for the irrigation actuator sequencer
package rega_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIP,
        SPRAY,
        DEAD,
        FAULT
    } seqState_e;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_MIN_ON_CYCLES = 1000;
    localparam int DEF_DEAD_CYCLES   = 100;
    localparam int DEF_MAX_ON_CYCLES = 60000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a bundle of asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/irrigation_actuator_sequencer.sv
// rtl/irrigation_actuator_sequencer.sv - drip/sprinkler/inlet actuator sequencer, optional watchdog via SEQ_WATCHDOG_EN
module irrigation_actuator_sequencer
    import rega_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MIN_ON_CYCLES = DEF_MIN_ON_CYCLES,
    parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
    parameter int MAX_ON_CYCLES = DEF_MAX_ON_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gotejamentoReq,
    input  logic aspersaoReq,
    input  logic valvulaEntradaReq,
    input  logic alarme,
    input  logic clrFault,
    output logic gotejamentoOut,
    output logic aspersaoOut,
    output logic valvulaEntradaOut,
    output logic busy,
    output logic timeoutFlag
);

    localparam logic [CNT_W-1:0] MIN_ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
`ifdef SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MAX_ON_LAST = CNT_W'(MAX_ON_CYCLES - 1);
`endif

    logic [3:0] asyncIn;
    logic [3:0] syncOut;
    logic       gotejamentoReqS;
    logic       aspersaoReqS;
    logic       valvulaEntradaReqS;
    logic       alarmeS;

    seqState_e       state;
    seqState_e       nextState;
    logic [CNT_W-1:0] cnt;
    logic            ownReq;
    logic            otherReq;
    logic            valvulaReg;

    assign asyncIn = {alarme, valvulaEntradaReq, aspersaoReq, gotejamentoReq};

    sync_2ff #(
        .WIDTH(4)
    ) uSync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (asyncIn),
        .q    (syncOut)
    );

    assign gotejamentoReqS    = syncOut[0];
    assign aspersaoReqS       = syncOut[1];
    assign valvulaEntradaReqS = syncOut[2];
    assign alarmeS            = syncOut[3];

    // The active episode's own request and the competing one, so DRIP and SPRAY share one rule set.
    assign ownReq   = (state == SPRAY) ? aspersaoReqS : gotejamentoReqS;
    assign otherReq = (state == SPRAY) ? gotejamentoReqS : aspersaoReqS;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; alarm always wins, and an episode can only end through DEAD.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!alarmeS) begin
                    if (gotejamentoReqS && !aspersaoReqS) begin
                        nextState = DRIP;
                    end else if (aspersaoReqS && !gotejamentoReqS) begin
                        nextState = SPRAY;
                    end
                end
            end
            DRIP, SPRAY: begin
                if (alarmeS) begin
                    nextState = DEAD;
`ifdef SEQ_WATCHDOG_EN
                end else if (cnt == MAX_ON_LAST && ownReq) begin
                    nextState = FAULT;
`endif
                end else if ((!ownReq || otherReq) && cnt >= MIN_ON_LAST) begin
                    nextState = DEAD;
                end
            end
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    nextState = IDLE;
                end
            end
            FAULT: begin
`ifdef SEQ_WATCHDOG_EN
                if (clrFault && !gotejamentoReqS && !aspersaoReqS) begin
                    nextState = IDLE;
                end
`else
                nextState = IDLE;
`endif
            end
            default: nextState = IDLE;
        endcase
    end

    // Shared counter: on-time in DRIP/SPRAY (saturating), dead time in DEAD, frozen in FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                DRIP, SPRAY: begin
                    if (nextState == state) begin
                        cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
                    end else if (nextState == DEAD) begin
                        cnt <= '0;
                    end
                end
                DEAD: begin
                    cnt <= (nextState == DEAD) ? cnt + 1'b1 : '0;
                end
                FAULT: begin
                    cnt <= cnt;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Inlet valve follows its request, dropped by alarm, independent of the irrigation FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valvulaReg <= 1'b0;
        end else begin
            valvulaReg <= valvulaEntradaReqS & ~alarmeS;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        gotejamentoOut    = 1'b0;
        aspersaoOut       = 1'b0;
        busy              = 1'b0;
        valvulaEntradaOut = valvulaReg;
        case (state)
            DRIP: begin
                gotejamentoOut = 1'b1;
                busy           = 1'b1;
            end
            SPRAY: begin
                aspersaoOut = 1'b1;
                busy        = 1'b1;
            end
            DEAD: begin
                busy = 1'b1;
            end
            FAULT: begin
                valvulaEntradaOut = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    assign timeoutFlag = (state == FAULT);
`else
    logic unusedCfg;
    assign timeoutFlag = 1'b0;
    assign unusedCfg   = clrFault ^ (MAX_ON_CYCLES > MIN_ON_CYCLES);
`endif

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
// tb/tb_irrigation_actuator_sequencer.sv - scoreboard bench for irrigation_actuator_sequencer
module tb_irrigation_actuator_sequencer;

    localparam logic [4:0] E_IDLE   = 5'b00000;
    localparam logic [4:0] E_DRIP   = 5'b10010;
    localparam logic [4:0] E_SPRAY  = 5'b01010;
    localparam logic [4:0] E_SPRAYV = 5'b01110;
    localparam logic [4:0] E_DEAD   = 5'b00010;
    localparam logic [4:0] E_FAULT  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    logic gotejamentoReq;
    logic aspersaoReq;
    logic valvulaEntradaReq;
    logic alarme;
    logic clrFault;
    logic gotejamentoOut;
    logic aspersaoOut;
    logic valvulaEntradaOut;
    logic busy;
    logic timeoutFlag;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] expQ[$];
    string      tag;
    wire  [4:0] obs = {gotejamentoOut, aspersaoOut, valvulaEntradaOut, busy, timeoutFlag};

    irrigation_actuator_sequencer #(
        .CNT_W        (8),
        .MIN_ON_CYCLES(4),
        .DEAD_CYCLES  (3),
        .MAX_ON_CYCLES(20)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gotejamentoReq   (gotejamentoReq),
        .aspersaoReq      (aspersaoReq),
        .valvulaEntradaReq(valvulaEntradaReq),
        .alarme           (alarme),
        .clrFault         (clrFault),
        .gotejamentoOut   (gotejamentoOut),
        .aspersaoOut      (aspersaoOut),
        .valvulaEntradaOut(valvulaEntradaOut),
        .busy             (busy),
        .timeoutFlag      (timeoutFlag)
    );

    always #5 clk = ~clk;

    task automatic pushN(input logic [4:0] v, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(v);
    endtask

    task automatic checkNow(input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s observed=%b expected=<scoreboard empty>", tag, obs);
            end else begin
                checkNow(expQ.pop_front());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        gotejamentoReq = 1'b0;
        aspersaoReq = 1'b0;
        valvulaEntradaReq = 1'b0;
        alarme = 1'b0;
        clrFault = 1'b0;

        tag = "reset_state";
        #2;
        checkNow(E_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        pushN(E_IDLE, 3);
        run(3);

        tag = "basic_drip";
        gotejamentoReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_DRIP, 10);
        run(10);
        gotejamentoReq = 1'b0;
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 2);
        run(7);

        tag = "min_on_time";
        aspersaoReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_SPRAY, 4);
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 2);
        run(1);
        aspersaoReq = 1'b0;
        run(10);

        tag = "mode_change";
        gotejamentoReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_DRIP, 6);
        run(8);
        gotejamentoReq = 1'b0;
        aspersaoReq = 1'b1;
        pushN(E_DRIP, 2);
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 1);
        pushN(E_SPRAY, 5);
        run(11);
        aspersaoReq = 1'b0;
        pushN(E_SPRAY, 2);
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 2);
        run(7);

        tag = "alarm_override";
        aspersaoReq = 1'b1;
        valvulaEntradaReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_SPRAYV, 4);
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 6);
        run(4);
        alarme = 1'b1;
        run(11);
        alarme = 1'b0;
        aspersaoReq = 1'b0;
        valvulaEntradaReq = 1'b0;
        pushN(E_IDLE, 3);
        run(3);

`ifdef SEQ_WATCHDOG_EN
        tag = "watchdog";
        gotejamentoReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_DRIP, 20);
        pushN(E_FAULT, 3);
        run(25);
        tag = "clr_ignored";
        clrFault = 1'b1;
        pushN(E_FAULT, 1);
        run(1);
        clrFault = 1'b0;
        pushN(E_FAULT, 2);
        run(2);
        gotejamentoReq = 1'b0;
        pushN(E_FAULT, 2);
        run(2);
        tag = "clr_fault";
        clrFault = 1'b1;
        pushN(E_IDLE, 1);
        run(1);
        clrFault = 1'b0;
        pushN(E_IDLE, 2);
        run(2);
`else
        tag = "no_watchdog";
        gotejamentoReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_DRIP, 28);
        run(30);
        gotejamentoReq = 1'b0;
        pushN(E_DRIP, 2);
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 2);
        run(7);
`endif

        tag = "async_reset";
        gotejamentoReq = 1'b1;
        pushN(E_IDLE, 2);
        pushN(E_DRIP, 3);
        run(5);
        rst_n = 1'b0;
        #1;
        checkNow(E_IDLE);
        @(negedge clk);
        checkNow(E_IDLE);
        rst_n = 1'b1;
        tag = "reset_restart";
        pushN(E_IDLE, 2);
        pushN(E_DRIP, 1);
        run(3);
        gotejamentoReq = 1'b0;
        pushN(E_DRIP, 3);
        pushN(E_DEAD, 3);
        pushN(E_IDLE, 2);
        run(8);

        tag = "scoreboard_drained";
        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=0", tag, expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
